// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl - pipeline sequencing controller for the 5-stage RV32I core.
//
// Drives the stall/flush controls of the PC and the IF/ID, ID/EX, EX/MEM and
// MEM/WB pipeline registers. It resolves four conditions:
//   - instruction-memory warm-up after reset (BOOT)
//   - data-memory wait states (highest priority; freezes the pipeline)
//   - taken branches/jumps resolved in EX (front-end flush)
//   - load-use hazards (one-cycle bubble)
// It also raises a sticky watchdog flag when the data memory stops responding.
//
// Control outputs are combinational from the registered state and the
// current inputs, so they act on the same edge the pipeline registers sample.
//
// Parameters:
//   BOOT_CYCLES  warm-up cycles after reset release (1..15)
//   TIMEOUT      consecutive wait cycles that set timeout_err
//   CNT_W        width of the wait counter
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rs1_id, rs2_id           source register fields of the ID instruction
//   uses_rs1_id, uses_rs2_id ID instruction reads rs1 / rs2
//   rd_ex, mem_read_ex       destination register / load flag of EX
//   branch_taken_ex          EX resolved a taken branch or jump
//   dmem_req_mem, dmem_ready data-memory request and completion
//   pc_stall .. mem_wb_flush pipeline stall/flush controls
//   timeout_err              sticky data-memory timeout flag
//   stall_cycles, flush_events  performance counters (optional)
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the 32-bit saturating
// performance counters stall_cycles and flush_events.
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        uses_rs1_id,
    input  logic        uses_rs2_id,
    input  logic [4:0]  rd_ex,
    input  logic        mem_read_ex,
    input  logic        branch_taken_ex,
    input  logic        dmem_req_mem,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        mem_wb_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
`endif
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [3:0]       BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           fsm_r;
    logic [3:0]       boot_cnt_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_inc_s;
    logic             timeout_err_r;
    logic             mem_wait_s;
    logic             load_use_s;

    assign mem_wait_s = dmem_req_mem & ~dmem_ready;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use_s = mem_read_ex & (rd_ex != 5'd0) &
                        ((uses_rs1_id & (rs1_id == rd_ex)) |
                         (uses_rs2_id & (rs2_id == rd_ex)));

    // Saturating increment of the wait counter.
    always_comb begin
        wait_cnt_inc_s = wait_cnt_r;
        if (wait_cnt_r != CNT_MAX) begin
            wait_cnt_inc_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_inc_s = CNT_MAX;
        end
    end

    // Stall/flush decode: BOOT holds the front end, otherwise priority chain.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        case (fsm_r)
            ST_RUN, ST_WAIT: begin
                if (mem_wait_s) begin
                    // Freeze everything; EX is held so a pending branch
                    // survives until the memory completes.
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_flush = 1'b1;
                end else if (branch_taken_ex) begin
                    // ID holds a wrong-path instruction, so it is flushed
                    // rather than stalled even if it matches a load.
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                end else if (load_use_s) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_flush  = 1'b1;
                end else begin
                    pc_stall     = 1'b0;
                end
            end
            default: begin
                // BOOT (and any illegal encoding) holds the PC and flushes.
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
        endcase
    end

    // State machine, boot counter, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r         <= ST_BOOT;
            boot_cnt_r    <= 4'd0;
            wait_cnt_r    <= {CNT_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            case (fsm_r)
                ST_BOOT: begin
                    boot_cnt_r <= boot_cnt_r + 4'd1;
                    wait_cnt_r <= {CNT_W{1'b0}};
                    if (boot_cnt_r == BOOT_LAST) begin
                        fsm_r <= ST_RUN;
                    end else begin
                        fsm_r <= ST_BOOT;
                    end
                end
                ST_RUN: begin
                    wait_cnt_r <= {CNT_W{1'b0}};
                    if (mem_wait_s) begin
                        fsm_r <= ST_WAIT;
                    end else begin
                        fsm_r <= ST_RUN;
                    end
                end
                ST_WAIT: begin
                    wait_cnt_r <= wait_cnt_inc_s;
                    // Flag raised on the edge the counter reaches TIMEOUT;
                    // the stall itself is never released by the watchdog.
                    if (wait_cnt_inc_s >= TIMEOUT_C) begin
                        timeout_err_r <= 1'b1;
                    end else begin
                        timeout_err_r <= timeout_err_r;
                    end
                    if (dmem_ready) begin
                        fsm_r <= ST_RUN;
                    end else begin
                        fsm_r <= ST_WAIT;
                    end
                end
                default: begin
                    fsm_r      <= ST_BOOT;
                    boot_cnt_r <= 4'd0;
                    wait_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign timeout_err = timeout_err_r;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_events_r;

    // Saturating performance counters; BOOT cycles are excluded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_r <= 32'd0;
            flush_events_r <= 32'd0;
        end else begin
            if ((fsm_r != ST_BOOT) && pc_stall && (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if ((fsm_r != ST_BOOT) && branch_taken_ex && !mem_wait_s &&
                (flush_events_r != 32'hFFFF_FFFF)) begin
                flush_events_r <= flush_events_r + 32'd1;
            end else begin
                flush_events_r <= flush_events_r;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_events = flush_events_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl - scoreboard bench for hazard_ctrl.
// Each stimulus step drives inputs shortly after a rising edge and queues the
// hand-computed output vector; a monitor samples on the falling edge and
// compares against the queue head.
// Vector bit order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
//                    id_ex_flush, ex_mem_stall, mem_wb_flush, timeout_err}
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1_id = 5'd0;
    logic [4:0] rs2_id = 5'd0;
    logic       uses_rs1_id = 1'b0;
    logic       uses_rs2_id = 1'b0;
    logic [4:0] rd_ex = 5'd0;
    logic       mem_read_ex = 1'b0;
    logic       branch_taken_ex = 1'b0;
    logic       dmem_req_mem = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic       id_ex_flush, ex_mem_stall, mem_wb_flush, timeout_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    hazard_ctrl #(.BOOT_CYCLES(2), .TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
        .branch_taken_ex(branch_taken_ex),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] V_BOOT = 8'hA8;
    localparam logic [7:0] V_MEMW = 8'hD6;
    localparam logic [7:0] V_MEME = 8'hD7;
    localparam logic [7:0] V_BR   = 8'h28;
    localparam logic [7:0] V_LU   = 8'hC8;
    localparam logic [7:0] V_IDLE = 8'h00;
    localparam logic [7:0] V_ERR  = 8'h01;

    typedef struct {
        logic [7:0] vec;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Drive one cycle of stimulus and queue its expected output vector.
    task automatic step(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic req,
                        input logic rdy, input logic [7:0] ev, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; rs1_id = s1; rs2_id = s2; uses_rs1_id = u1; uses_rs2_id = u2;
        rd_ex = rd; mem_read_ex = mr; branch_taken_ex = br;
        dmem_req_mem = req; dmem_ready = rdy;
        e.vec = ev;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [7:0] ev, input string nm);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ev, nm);
    endtask

    // Monitor: compare the DUT outputs against the queue head each cycle.
    always @(negedge clk) begin
        logic [7:0] act;
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                   id_ex_flush, ex_mem_stall, mem_wb_flush, timeout_err};
            total++;
            if (act !== e.vec) begin
                bad++;
                $display("FAIL %s: got %b expected %b", e.name, act, e.vec);
            end
        end
    end

    initial begin
        // 1. Reset and boot; a memory stall during boot must be ignored.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, V_BOOT, "reset_hold");
        idle(V_BOOT, "boot_cycle0");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_BOOT, "boot_cycle1_ignores_mem");
        idle(V_IDLE, "boot_done_run");

        // 2. Load-use hazards.
        step(1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, V_LU,   "load_use_rs2");
        idle(V_IDLE, "load_use_single_bubble");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, V_IDLE, "load_use_x0");
        step(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, V_LU,   "load_use_rs1");
        step(1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, V_IDLE, "rs1_match_unused");
        step(1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE, "match_not_load");
        step(1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, V_IDLE, "load_no_match");

        // 3. Branch wins over load-use.
        step(1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, V_BR,   "branch_over_load_use");
        idle(V_IDLE, "after_branch");

        // 4. Three-cycle memory wait with a branch held in EX.
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, V_MEMW, "mem_wait_c1");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, V_MEMW, "mem_wait_c2");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, V_MEMW, "mem_wait_c3");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, V_BR,   "branch_on_ready");
        idle(V_IDLE, "after_wait");

        // 5. Timeout: one RUN cycle plus four WAIT cycles sets the flag.
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MEMW, "to_enter");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MEMW, "to_wait1");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MEMW, "to_wait2");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MEMW, "to_wait3");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MEMW, "to_wait4");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MEME, "to_flag_set");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, V_ERR,  "to_ready_sticky");
        idle(V_ERR, "to_sticky_run");

        // 6. Asynchronous reset while in WAIT, then boot restarts.
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MEME, "pre_reset_enter");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MEME, "pre_reset_wait");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_BOOT, "async_reset_mid_wait");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_BOOT, "reset_held");
        idle(V_BOOT, "reboot_cycle0");
        idle(V_BOOT, "reboot_cycle1");
        idle(V_IDLE, "reboot_run");
        step(1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, V_LU,   "post_reboot_load_use");

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
